// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: one shared datapath sequenced by an FSM,
// a single req/ready memory port, start/stop control, halt and retire count.
module multi_cycle_cpu #(
   parameter int          ADDR_W   = 32,
   parameter int          NUM_REGS = 32,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i,
   input  logic              mem_ready_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              halt_o,
   output logic [31:0]       retired_o
);

   // state  | meaning
   // IDLE   | stopped, outputs quiet, waiting for start_i
   // FETCH  | instruction read at PC, PC+4 on completion
   // DECODE | operand read, branch target into ALUOut, legality check
   // EXEC   | ALU op / address calc / branch / jump
   // MEM    | data read (lw) or write (sw) at ALUOut
   // WB     | register file write
   // HALT   | illegal opcode or misaligned access, left only by reset
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   localparam logic [ADDR_W-1:0] RST_PC = RESET_PC[ADDR_W-1:0];

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
   logic [31:0]       ir_q, ir_d, a_q, a_d, b_q, b_d;
   logic [31:0]       alu_q, alu_d, mdr_q, mdr_d, wdata_q, wdata_d;
   logic [31:0]       retired_q, retired_d;
   logic              req_q, req_d, we_q, we_d, halt_q, halt_d;
   logic [31:0]       gpr_q [32];
   logic [31:0]       gpr_d [32];

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, dest;
   logic [31:0] sext_imm, pc32, jump_tgt, alu_res, wb_data;
   logic        is_rtype, is_addi, is_lw, is_sw, is_beq, is_j, legal;
   logic        boundary;

   assign opcode   = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign funct    = ir_q[5:0];
   assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
   assign pc32     = 32'(pc_q);
   assign jump_tgt = {pc32[31:28], ir_q[25:0], 2'b00};

   assign is_rtype = (opcode == 6'h00);
   assign is_addi  = (opcode == 6'h08);
   assign is_lw    = (opcode == 6'h23);
   assign is_sw    = (opcode == 6'h2B);
   assign is_beq   = (opcode == 6'h04);
   assign is_j     = (opcode == 6'h02);
   assign legal    = (is_rtype && (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}))
                   || is_addi || is_lw || is_sw || is_beq || is_j;

   assign dest    = is_rtype ? rd : rt;
   assign wb_data = is_lw ? mdr_q : alu_q;

   always_comb begin
      alu_res = a_q + sext_imm;
      if (is_rtype) begin
         case (funct)
            6'h20:   alu_res = a_q + b_q;
            6'h22:   alu_res = a_q - b_q;
            6'h24:   alu_res = a_q & b_q;
            6'h25:   alu_res = a_q | b_q;
            6'h2A:   alu_res = {31'b0, $signed(a_q) < $signed(b_q)};
            default: alu_res = '0;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      alu_d     = alu_q;
      mdr_d     = mdr_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      halt_d    = halt_q;
      retired_d = retired_q;
      gpr_d     = gpr_q;
      boundary  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_FETCH;
               req_d   = 1'b1;
               we_d    = 1'b0;
               addr_d  = pc_q;
            end
         end
         S_FETCH: begin
            if (mem_ready_i) begin
               ir_d    = mem_rdata_i;
               pc_d    = pc_q + ADDR_W'(4);
               req_d   = 1'b0;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d   = (rs != 5'd0 && int'(rs) < NUM_REGS) ? gpr_q[rs] : '0;
            b_d   = (rt != 5'd0 && int'(rt) < NUM_REGS) ? gpr_q[rt] : '0;
            alu_d = pc32 + (sext_imm << 2);
            if (!legal) begin
               state_d = S_HALT;
               halt_d  = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_lw || is_sw) begin
               alu_d = alu_res;
               if (alu_res[1:0] != 2'b00) begin
                  state_d = S_HALT;
                  halt_d  = 1'b1;
               end else begin
                  state_d = S_MEM;
                  req_d   = 1'b1;
                  we_d    = is_sw;
                  addr_d  = alu_res[ADDR_W-1:0];
                  wdata_d = is_sw ? b_q : '0;
               end
            end else if (is_beq) begin
               if (a_q == b_q) pc_d = alu_q[ADDR_W-1:0];
               boundary = 1'b1;
            end else if (is_j) begin
               pc_d     = jump_tgt[ADDR_W-1:0];
               boundary = 1'b1;
            end else begin
               alu_d   = alu_res;
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (mem_ready_i) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               wdata_d = '0;
               if (we_q) begin
                  boundary = 1'b1;
               end else begin
                  mdr_d   = mem_rdata_i;
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            // $0 and unimplemented registers silently absorb writes
            if (dest != 5'd0 && int'(dest) < NUM_REGS) gpr_d[dest] = wb_data;
            boundary = 1'b1;
         end
         S_HALT: begin
            req_d  = 1'b0;
            halt_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // Instruction boundary: retire, then either fetch from the new PC or park.
      if (boundary) begin
         retired_d = retired_q + 32'd1;
         state_d   = start_i ? S_FETCH : S_IDLE;
         req_d     = start_i;
         we_d      = 1'b0;
         wdata_d   = '0;
         addr_d    = start_i ? pc_d : '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= S_IDLE;
         pc_q      <= RST_PC;
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         alu_q     <= '0;
         mdr_q     <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         halt_q    <= 1'b0;
         retired_q <= '0;
         for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         a_q       <= a_d;
         b_q       <= b_d;
         alu_q     <= alu_d;
         mdr_q     <= mdr_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         halt_q    <= halt_d;
         retired_q <= retired_d;
         gpr_q     <= gpr_d;
      end
   end

   assign mem_req_o   = req_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign pc_o        = pc_q;
   assign halt_o      = halt_q;
   assign retired_o   = retired_q;

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Bench for multi_cycle_cpu: word memory with programmable wait states,
// store scoreboard, and scenario tasks for timing, control and fault paths.
module tb_multi_cycle_cpu;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        start_i = 1'b0;
   logic        mem_req_o, mem_we_o, mem_ready_i, halt_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, pc_o, retired_o;

   multi_cycle_cpu dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ready_i (mem_ready_i),
      .pc_o        (pc_o),
      .halt_o      (halt_o),
      .retired_o   (retired_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic [31:0] mem [64];
   wr_t         exp_wr [$];
   int          wait_n = 0;
   int          rd_idx = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   // written only by the memory model below
   int          cyc = 0;
   int          wait_cnt = 0;
   int          wr_cnt = 0;
   int          stab_err = 0;
   int          wait_seen = 0;
   int          req_013 = 0;
   logic [31:0] wr_addr [256];
   logic [31:0] wr_data [256];
   int          wr_cyc [256];
   logic        prev_wait = 1'b0;
   logic        prev_we = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [31:0] prev_wdata = '0;

   assign mem_ready_i = (wait_cnt >= wait_n);
   assign mem_rdata_i = mem[mem_addr_o[7:2]];

   always @(posedge clk_i) begin
      cyc <= cyc + 1;
      if (!rst_i) begin
         wait_cnt  <= 0;
         prev_wait <= 1'b0;
      end else begin
         if (mem_req_o && mem_addr_o == 32'h13) req_013 <= req_013 + 1;
         if (prev_wait && (!mem_req_o || mem_addr_o !== prev_addr ||
             mem_we_o !== prev_we || mem_wdata_o !== prev_wdata))
            stab_err <= stab_err + 1;
         if (mem_req_o && mem_ready_i) begin
            wait_cnt <= 0;
            if (mem_we_o && wr_cnt < 256) begin
               wr_addr[wr_cnt] <= mem_addr_o;
               wr_data[wr_cnt] <= mem_wdata_o;
               wr_cyc[wr_cnt]  <= cyc;
               wr_cnt          <= wr_cnt + 1;
            end
         end else if (mem_req_o) begin
            wait_cnt  <= wait_cnt + 1;
            wait_seen <= wait_seen + 1;
         end
         prev_wait  <= mem_req_o && !mem_ready_i;
         prev_addr  <= mem_addr_o;
         prev_we    <= mem_we_o;
         prev_wdata <= mem_wdata_o;
      end
   end

   function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'h00, fn};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000FFFF;
   endtask

   task automatic do_reset();
      start_i = 1'b0;
      rst_i   = 1'b0;
      tick(2);
      rst_i   = 1'b1;
      rd_idx  = wr_cnt;
      exp_wr.delete();
      tick(1);
   endtask

   task automatic wait_req(input int max, output bit ok);
      int t = 0;
      while (!mem_req_o && t < max) begin tick(1); t++; end
      ok = mem_req_o;
   endtask

   task automatic wait_retired(input logic [31:0] n, input int max, output bit ok);
      int t = 0;
      while (retired_o !== n && t < max) begin tick(1); t++; end
      ok = (retired_o === n);
   endtask

   task automatic wait_halt(input int max, output bit ok);
      int t = 0;
      while (halt_o !== 1'b1 && t < max) begin tick(1); t++; end
      ok = (halt_o === 1'b1);
   endtask

   // Pops every expected store and compares it with the next observed one.
   task automatic drain_scoreboard(input string tag, input int max);
      wr_t e;
      int  t;
      while (exp_wr.size() > 0) begin
         e = exp_wr.pop_front();
         t = 0;
         while (wr_cnt <= rd_idx && t < max) begin tick(1); t++; end
         n_chk++;
         if (wr_cnt <= rd_idx) begin
            n_fail++;
            $display("FAIL %s store: no write observed, required addr=%h data=%h", tag, e.addr, e.data);
         end else begin
            if (wr_addr[rd_idx] !== e.addr || wr_data[rd_idx] !== e.data) begin
               n_fail++;
               $display("FAIL %s store: got addr=%h data=%h, required addr=%h data=%h",
                        tag, wr_addr[rd_idx], wr_data[rd_idx], e.addr, e.data);
            end
            rd_idx++;
         end
      end
   endtask

   task automatic test_reset();
      start_i = 1'b1;
      rst_i   = 1'b0;
      tick(3);
      n_chk += 7;
      if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset req: got %b required 0", mem_req_o); end
      if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset we: got %b required 0", mem_we_o); end
      if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset addr: got %h required 0", mem_addr_o); end
      if (mem_wdata_o !== 32'h0) begin n_fail++; $display("FAIL reset wdata: got %h required 0", mem_wdata_o); end
      if (halt_o !== 1'b0) begin n_fail++; $display("FAIL reset halt: got %b required 0", halt_o); end
      if (retired_o !== 32'h0) begin n_fail++; $display("FAIL reset retired: got %0d required 0", retired_o); end
      if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset pc: got %h required 0", pc_o); end
      start_i = 1'b0;
   endtask

   task automatic test_basic();
      bit ok;
      int f;
      do_reset();
      clear_prog();
      wait_n = 0;
      mem[0] = i_type(6'h08, 5'd0, 5'd1, 16'd5);
      mem[1] = i_type(6'h08, 5'd0, 5'd2, 16'd7);
      mem[2] = r_type(5'd1, 5'd2, 5'd3, 6'h20);
      mem[3] = i_type(6'h2B, 5'd0, 5'd3, 16'h0010);
      exp_wr.push_back('{32'h10, 32'd12});
      start_i = 1'b1;
      wait_req(10, ok);
      f = cyc;
      n_chk++;
      if (!ok || mem_addr_o !== 32'h0) begin
         n_fail++; $display("FAIL basic first fetch: req=%b addr=%h, required req=1 addr=0", mem_req_o, mem_addr_o);
      end
      drain_scoreboard("basic", 60);
      n_chk += 2;
      if (rd_idx > 0 && wr_cyc[rd_idx-1] - f != 15) begin
         n_fail++; $display("FAIL basic sw timing: got %0d cycles required 15", wr_cyc[rd_idx-1] - f);
      end
      if (retired_o !== 32'd4) begin n_fail++; $display("FAIL basic retired: got %0d required 4", retired_o); end
   endtask

   task automatic test_wait_lw();
      bit ok;
      int f, s0, w0;
      do_reset();
      clear_prog();
      wait_n = 3;
      s0 = stab_err;
      w0 = wait_seen;
      mem[0]  = i_type(6'h23, 5'd0, 5'd4, 16'h0040);
      mem[1]  = i_type(6'h2B, 5'd0, 5'd4, 16'h0044);
      mem[16] = 32'hDEADBEEF;
      exp_wr.push_back('{32'h44, 32'hDEADBEEF});
      start_i = 1'b1;
      wait_req(10, ok);
      f = cyc;
      wait_retired(32'd1, 40, ok);
      n_chk++;
      if (!ok || cyc - f != 11) begin
         n_fail++; $display("FAIL lw wait latency: got %0d cycles (retired=%0d) required 11", cyc - f, retired_o);
      end
      drain_scoreboard("lw_wait", 80);
      n_chk += 2;
      if (stab_err != s0) begin n_fail++; $display("FAIL wait stability: got %0d changes required 0", stab_err - s0); end
      if (wait_seen - w0 < 6) begin n_fail++; $display("FAIL wait cycles: got %0d required >= 6", wait_seen - w0); end
   endtask

   task automatic test_branch();
      bit ok;
      int c0;
      do_reset();
      clear_prog();
      wait_n = 0;
      mem[0] = i_type(6'h08, 5'd0, 5'd1, 16'd3);
      mem[1] = i_type(6'h08, 5'd0, 5'd2, 16'd4);
      mem[2] = i_type(6'h04, 5'd1, 5'd2, 16'd5);
      mem[3] = {6'h02, 26'h8};
      mem[8] = i_type(6'h04, 5'd1, 5'd1, 16'hFFFF);
      start_i = 1'b1;
      wait_retired(32'd3, 30, ok);
      c0 = cyc;
      n_chk++;
      if (!ok || pc_o !== 32'hC) begin n_fail++; $display("FAIL beq not-taken pc: got %h required c", pc_o); end
      wait_retired(32'd4, 10, ok);
      n_chk += 2;
      if (!ok || pc_o !== 32'h20) begin n_fail++; $display("FAIL jump pc: got %h required 20", pc_o); end
      if (cyc - c0 != 3) begin n_fail++; $display("FAIL jump cycles: got %0d required 3", cyc - c0); end
      for (int k = 5; k < 8; k++) begin
         c0 = cyc;
         wait_retired(32'(k), 10, ok);
         n_chk += 2;
         if (!ok || pc_o !== 32'h20) begin n_fail++; $display("FAIL beq loop pc: got %h required 20", pc_o); end
         if (cyc - c0 != 3) begin n_fail++; $display("FAIL beq loop cycles: got %0d required 3", cyc - c0); end
      end
      tick(1);
      n_chk++;
      if (pc_o !== 32'h24) begin n_fail++; $display("FAIL beq post-fetch pc: got %h required 24", pc_o); end
   endtask

   task automatic test_alu();
      logic [31:0] a, b;
      do_reset();
      clear_prog();
      wait_n = 1;
      a = 32'hFFFFFFFD;
      b = 32'd5;
      mem[0] = i_type(6'h08, 5'd0, 5'd1, 16'hFFFD);
      mem[1] = i_type(6'h08, 5'd0, 5'd2, 16'd5);
      mem[2] = r_type(5'd1, 5'd2, 5'd3, 6'h2A);
      mem[3] = r_type(5'd2, 5'd1, 5'd4, 6'h2A);
      mem[4] = r_type(5'd1, 5'd2, 5'd5, 6'h24);
      mem[5] = r_type(5'd1, 5'd2, 5'd6, 6'h25);
      mem[6] = r_type(5'd1, 5'd2, 5'd7, 6'h22);
      mem[7] = r_type(5'd1, 5'd2, 5'd8, 6'h20);
      for (int r = 3; r <= 8; r++) mem[8 + r - 3] = i_type(6'h2B, 5'd0, 5'(r), 16'(32'h80 + 4 * (r - 3)));
      exp_wr.push_back('{32'h80, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0});
      exp_wr.push_back('{32'h84, ($signed(b) < $signed(a)) ? 32'd1 : 32'd0});
      exp_wr.push_back('{32'h88, a & b});
      exp_wr.push_back('{32'h8C, a | b});
      exp_wr.push_back('{32'h90, a - b});
      exp_wr.push_back('{32'h94, a + b});
      start_i = 1'b1;
      drain_scoreboard("alu", 150);
   endtask

   task automatic test_halt();
      bit ok;
      int reqs = 0;
      do_reset();
      clear_prog();
      wait_n = 0;
      mem[0] = i_type(6'h08, 5'd0, 5'd1, 16'd1);
      mem[1] = i_type(6'h08, 5'd0, 5'd2, 16'd2);
      mem[2] = 32'hFC000000;
      start_i = 1'b1;
      wait_halt(40, ok);
      n_chk += 3;
      if (!ok) begin n_fail++; $display("FAIL illegal halt: got halt=%b required 1", halt_o); end
      if (retired_o !== 32'd2) begin n_fail++; $display("FAIL illegal retired: got %0d required 2", retired_o); end
      if (pc_o !== 32'hC) begin n_fail++; $display("FAIL illegal pc: got %h required c", pc_o); end
      for (int i = 0; i < 10; i++) begin
         if (mem_req_o) reqs++;
         tick(1);
      end
      n_chk += 2;
      if (reqs != 0) begin n_fail++; $display("FAIL halt req: got %0d requests required 0", reqs); end
      if (halt_o !== 1'b1 || retired_o !== 32'd2) begin
         n_fail++; $display("FAIL halt sticky: got halt=%b retired=%0d required 1/2", halt_o, retired_o);
      end
   endtask

   task automatic test_misaligned();
      bit ok;
      int q0;
      do_reset();
      clear_prog();
      wait_n = 0;
      q0 = req_013;
      mem[0] = i_type(6'h08, 5'd0, 5'd1, 16'd9);
      mem[1] = i_type(6'h08, 5'd0, 5'd2, 16'd4);
      mem[2] = r_type(5'd1, 5'd2, 5'd0, 6'h22);
      mem[3] = i_type(6'h2B, 5'd0, 5'd0, 16'h0020);
      mem[4] = i_type(6'h23, 5'd0, 5'd5, 16'h0013);
      exp_wr.push_back('{32'h20, 32'h0});
      start_i = 1'b1;
      drain_scoreboard("zero_reg", 40);
      wait_halt(20, ok);
      n_chk += 4;
      if (!ok) begin n_fail++; $display("FAIL misaligned halt: got halt=%b required 1", halt_o); end
      if (retired_o !== 32'd4) begin n_fail++; $display("FAIL misaligned retired: got %0d required 4", retired_o); end
      if (pc_o !== 32'h14) begin n_fail++; $display("FAIL misaligned pc: got %h required 14", pc_o); end
      if (req_013 != q0 || mem_req_o !== 1'b0) begin
         n_fail++; $display("FAIL misaligned req: got %0d requests to 13 req=%b required none", req_013 - q0, mem_req_o);
      end
   endtask

   task automatic test_start_stop();
      bit ok;
      int reqs = 0;
      do_reset();
      clear_prog();
      wait_n = 0;
      mem[0] = i_type(6'h08, 5'd0, 5'd1, 16'd2);
      mem[1] = i_type(6'h08, 5'd0, 5'd2, 16'd3);
      mem[2] = r_type(5'd1, 5'd2, 5'd3, 6'h20);
      mem[3] = i_type(6'h2B, 5'd0, 5'd3, 16'h0030);
      exp_wr.push_back('{32'h30, 32'd5});
      start_i = 1'b1;
      wait_retired(32'd2, 20, ok);
      tick(2);
      start_i = 1'b0;
      wait_retired(32'd3, 10, ok);
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (mem_req_o) reqs++;
      end
      n_chk += 3;
      if (!ok || retired_o !== 32'd3) begin n_fail++; $display("FAIL stop retired: got %0d required 3", retired_o); end
      if (reqs != 0) begin n_fail++; $display("FAIL stop idle req: got %0d requests required 0", reqs); end
      if (pc_o !== 32'hC) begin n_fail++; $display("FAIL stop pc: got %h required c", pc_o); end
      start_i = 1'b1;
      wait_req(5, ok);
      n_chk++;
      if (!ok || mem_addr_o !== 32'hC) begin
         n_fail++; $display("FAIL resume fetch: req=%b addr=%h required req=1 addr=c", mem_req_o, mem_addr_o);
      end
      drain_scoreboard("resume", 40);
   endtask

   task automatic test_reset_mid_mem();
      bit ok;
      int t = 0;
      int w0;
      do_reset();
      clear_prog();
      wait_n = 4;
      mem[0] = i_type(6'h08, 5'd0, 5'd1, 16'd1);
      mem[1] = i_type(6'h2B, 5'd0, 5'd1, 16'h0034);
      start_i = 1'b1;
      while (!(mem_req_o && mem_we_o) && t < 40) begin tick(1); t++; end
      ok = mem_req_o && mem_we_o;
      w0 = wr_cnt;
      #1 rst_i = 1'b0;
      #1;
      n_chk += 4;
      if (!ok || mem_req_o !== 1'b0) begin n_fail++; $display("FAIL mid-MEM reset req: got %b (reached MEM=%b) required 0", mem_req_o, ok); end
      if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL mid-MEM reset we: got %b required 0", mem_we_o); end
      if (pc_o !== 32'h0) begin n_fail++; $display("FAIL mid-MEM reset pc: got %h required 0", pc_o); end
      if (retired_o !== 32'h0) begin n_fail++; $display("FAIL mid-MEM reset retired: got %0d required 0", retired_o); end
      start_i = 1'b0;
      tick(3);
      rst_i = 1'b1;
      tick(2);
      n_chk++;
      if (wr_cnt != w0) begin n_fail++; $display("FAIL mid-MEM reset store: got %0d stores required 0", wr_cnt - w0); end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_prog();
      test_reset();
      test_basic();
      test_wait_lw();
      test_branch();
      test_alu();
      test_halt();
      test_misaligned();
      test_start_stop();
      test_reset_mid_mem();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_cycle_cpu.md
Name: multi_cycle_cpu

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS core.
- One unified memory port with a req/ready handshake, so instruction and data memory may have any latency.
- A sequencing FSM reuses a single datapath across FETCH/DECODE/EXEC/MEM/WB.
- Adds start/stop control, halt detection and a retired-instruction counter.
- Sits at CPU top level in place of the single-cycle datapath; the memory model sits outside.

Parameters:
ADDR_W, 32, PC and memory address width (16..32); PC arithmetic wraps modulo 2^ADDR_W
NUM_REGS, 32, implemented GPRs (8, 16 or 32); reads of index >= NUM_REGS return 0, writes to it are dropped
RESET_PC, 0, PC value loaded on reset (word aligned)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
start_i  in  1  level; high = run, low = stop at next instruction boundary
mem_req_o  out  1  memory request
mem_we_o  out  1  1 = write (sw), 0 = read
mem_addr_o  out  ADDR_W  byte address
mem_wdata_o  out  32  store data
mem_rdata_i  in  32  read data, valid in the cycle mem_ready_i=1
mem_ready_i  in  1  transfer completes in the cycle req=1 and ready=1
pc_o  out  ADDR_W  architectural PC
halt_o  out  1  sticky; core stopped on an illegal opcode or a misaligned access
retired_o  out  32  retired-instruction count, wraps at 2^32

Behaviour:
- Reset (rst_i=0, async):
  - state=IDLE; PC=RESET_PC; all GPRs=0; IR/A/B/ALUOut/MDR=0.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, halt_o=0, retired_o=0.
  - Reset mid-transfer aborts it immediately; no register or PC update.
- Supported instructions: R-type (funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A), addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
- Illegal instructions: any other opcode, or any other funct on opcode 0x00, enters HALT.
- IDLE: outputs quiet. start_i=1 -> FETCH next cycle.
- FETCH:
  - Drives mem_req_o=1, mem_we_o=0, mem_addr_o=PC.
  - Holds all request signals until ready.
  - On ready: IR<=mem_rdata_i, PC<=PC+4 -> DECODE.
  - On entry to FETCH, if start_i=0 -> IDLE instead; no request is issued.
- DECODE:
  - A<=GPR[rs], B<=GPR[rt].
  - ALUOut<=PC+(sext(imm)<<2) (branch target).
  - Illegal opcode -> HALT; otherwise -> EXEC.
- EXEC:
  - R-type/addi: ALUOut<=result -> WB.
  - lw/sw: ALUOut<=A+sext(imm); if result[1:0]!=0 -> HALT, else -> MEM.
  - beq: if A==B then PC<=ALUOut; retire -> FETCH.
  - j: PC<={PC[ADDR_W-1:28], IR[25:0], 2'b00}, truncated/zero-extended to ADDR_W; retire -> FETCH.
- MEM:
  - mem_req_o=1, mem_addr_o=ALUOut; sw drives mem_we_o=1 and mem_wdata_o=B.
  - lw on ready: MDR<=mem_rdata_i -> WB.
  - sw on ready: retire -> FETCH.
- WB:
  - Writes GPR[rd] for R-type, GPR[rt] for addi (ALUOut) and lw (MDR); retire -> FETCH.
  - Writes to $0 are dropped; $0 always reads 0.
- Retire: retired_o increments by exactly 1 per completed instruction.
- HALT:
  - halt_o=1 and mem_req_o=0.
  - The faulting instruction does not retire; PC holds the value already incremented at FETCH.
  - Exits only via reset.
- Cycle counts with zero-wait memory (ready high in the same cycle as req): beq/j 3, R-type/addi/sw 4, lw 5. Each wait cycle adds 1.
- Arithmetic: add/sub/addi wrap modulo 2^32 with no overflow trap; slt is a signed compare.
- Handshake:
  - mem_ready_i is ignored while mem_req_o=0.
  - mem_req_o deasserts in the cycle after the completing cycle, unless the next state issues a new request.
- start_i falling mid-instruction: the instruction completes; the core enters IDLE at the next FETCH boundary. PC and GPRs are preserved, and resuming continues from PC.

Test Plan:
1. Reset, start_i=1, zero-wait memory; program addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,0x10($0) -> write at address 0x10 with data 12; retired_o=4 after 15 cycles from the first FETCH.
2. lw with mem_ready_i delayed 3 cycles in FETCH and in MEM -> mem_addr_o/mem_req_o stable across the wait; instruction completes in 11 cycles; loaded value appears in rt.
3. beq $1,$1,-1 -> PC returns to the branch address each 3 cycles; beq with unequal operands -> PC+4.
4. Opcode 0x3F at PC 0x8 -> halt_o=1, mem_req_o=0 thereafter, retired_o unchanged, pc_o=0xC.
5. lw from address 0x13 -> HALT with no memory request in MEM; sub $0,$1,$2 -> $0 still reads 0.
6. Deassert start_i during EXEC of an add -> add writes back, core goes to IDLE; reassert -> fetch resumes at the next PC. rst_i low mid-MEM -> mem_req_o=0 immediately, PC=RESET_PC.
